rr_select_mux: RTL and testbench
================================

// Module: rr_select_mux
// PURPOSE
//   Parametrised N-to-1 datapath selector with one registered output stage and valid/ready handshakes.
//   Successor to the fixed 8:1 32-bit combinational mux.
//   Adds two selection modes: direct select, or round-robin arbitration among valid inputs.
//   Sits between the register file, ALU and immediate sources and the writeback/result path.
// PARAMETERS
//   WIDTH   32  data width per channel
//   N       8   channel count, N >= 2
//   SEL_W   $clog2(N)  localparam, select/source index width
// PORTS
//   Clk        in   1         clock, all state updates on rising edge
//   Rst_n      in   1         asynchronous active-low reset
//   mode       in   1         0 = direct select, 1 = round-robin
//   sel        in   SEL_W     channel index used in direct mode
//   in_data    in   N*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   in   N         per-channel valid
//   in_ready   out  N         per-channel ready (combinational, one-hot or zero)
//   out_data   out  WIDTH     registered selected word
//   out_valid  out  1         output register holds a word
//   out_ready  in   1         downstream accepts
//   out_src    out  SEL_W     channel index the held word came from
// BEHAVIOUR
//   Reset (async, Rst_n=0): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1.
//     Any held word is dropped; it is not replayed after reset.
//   Output-stage state: EMPTY (out_valid=0) or FULL (out_valid=1).
//     can_load = !out_valid | out_ready.
//   Grant (combinational, evaluated every cycle):
//     mode 0: grant = sel, granted only when sel < N and in_valid[sel]=1.
//       sel >= N (non-power-of-2 N) grants nothing.
//     mode 1: grant = first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... mod N.
//       No valid input means no grant.
//   in_ready[grant] = can_load & granted. All other in_ready bits = 0.
//   Transfer in: in_valid[g] & in_ready[g]. At the next edge: out_data <= ch g, out_src <= g,
//     out_valid <= 1; in mode 1 also rr_ptr <= g.
//   rr_ptr changes only on an accepted transfer in mode 1; mode 0 leaves it untouched.
//   Transfer out: out_valid & out_ready. No new grant that cycle means out_valid <= 0.
//   Latency: 1 cycle input-to-output. Throughput 1 word/cycle, back-to-back when out_ready=1.
//   Simultaneous out-drain and in-load in FULL: new word replaces old in the same edge.
//   Backpressure: while out_valid=1 and out_ready=0, out_data/out_src are held stable
//     and in_ready is all 0.
//   Mode or sel change: affects only the next grant; the held word is unaffected.
//   Wrap-around: rr_ptr=N-1 searches from index 0. A single valid requester
//     is granted every cycle.
//   No combinational path from out_ready to out_data. out_ready reaches in_ready
//     (one-deep pipeline, no skid).
// STRUCTURE
//   Package mips_sel_pkg: MODE_DIRECT=1'b0, MODE_RR=1'b1 constants.
//   Sub-module rr_priority_pick: combinational rotating-priority encoder.
//     Parameter N. Inputs req[N], ptr[SEL_W]. Outputs gnt_idx[SEL_W], gnt_any.
//   Top level: grant mux, output register, rr_ptr register.
// TESTING
//   Reset check: assert Rst_n=0 mid-stream while FULL.
//     -> out_valid=0, out_data=0, out_src=0 immediately, without waiting for an edge.
//     -> After release, first mode-1 grant goes to the lowest valid index.
//   Direct mode: N=8, sel=3, ch3=0xDEADBEEF, in_valid=8'hFF, out_ready=1.
//     -> in_ready=8'h08; next cycle out_data=0xDEADBEEF, out_src=3.
//   Round-robin: in_valid=8'b1010_0101 held, out_ready=1.
//     -> out_src sequence 0,2,5,7,0,2 on consecutive cycles, one word per cycle.
//   Backpressure: load a word, hold out_ready=0 for 4 cycles.
//     -> out_data and out_src stable, in_ready=0 throughout.
//     -> Release: drain, and the new word loads on the same edge.
//   Edge cases at N=5, WIDTH=16: sel=6 in mode 0 -> no in_ready, out_valid falls after drain.
//     -> Mode 0->1 switch mid-stream leaves the held word intact.

Source files
------------

// File: rtl/mips_sel_pkg.sv
// Shared constants for the result-path selector.
// Mode encodings used by rr_select_mux and its bench.
package mips_sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef logic sel_mode_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set req bit after ptr, modulo N.
// Purely combinational; ptr itself has the lowest priority.
module rr_priority_pick #(
  parameter int N = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_idx = SEL_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_select_mux.sv
// N-to-1 selector with direct or round-robin grant and one
// registered output stage on a valid/ready handshake.
module rr_select_mux
  import mips_sel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
);

  localparam int NP2 = 1 << SEL_W;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [NP2-1:0]   vld_ext;
  logic             dir_any;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] pick_data;

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Zero-padded valids make out-of-range sel grant nothing.
  assign vld_ext = NP2'(in_valid);
  assign dir_any = vld_ext[sel];

  assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
  assign gnt_any  = (mode == MODE_RR) ? rr_any : dir_any;
  assign can_load = !out_valid | out_ready;
  assign load     = can_load & gnt_any;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && (gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        pick_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N - 1);
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pick_data;
        out_src   <= gnt_idx;
        if (mode == MODE_RR) begin
          rr_ptr <= gnt_idx;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_select_mux.sv
// Bench for rr_select_mux at N=8/W=32 and N=5/W=16.
// Directed scenarios plus a randomized run against a queue-free model.
module tb_rr_select_mux;
  import mips_sel_pkg::*;

  logic         Clk;
  logic         Rst_n;

  logic         mode8;
  logic [2:0]   sel8;
  logic [255:0] data8;
  logic [7:0]   valid8;
  logic [7:0]   irdy8;
  logic [31:0]  odata8;
  logic         ovalid8;
  logic         oready8;
  logic [2:0]   osrc8;

  logic         mode5;
  logic [2:0]   sel5;
  logic [79:0]  data5;
  logic [4:0]   valid5;
  logic [4:0]   irdy5;
  logic [15:0]  odata5;
  logic         ovalid5;
  logic         oready5;
  logic [2:0]   osrc5;

  int errors = 0;
  int checks = 0;

  rr_select_mux #(.WIDTH(32), .N(8)) dut8 (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .mode      (mode8),
    .sel       (sel8),
    .in_data   (data8),
    .in_valid  (valid8),
    .in_ready  (irdy8),
    .out_data  (odata8),
    .out_valid (ovalid8),
    .out_ready (oready8),
    .out_src   (osrc8)
  );

  rr_select_mux #(.WIDTH(16), .N(5)) dut5 (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .mode      (mode5),
    .sel       (sel5),
    .in_data   (data5),
    .in_valid  (valid5),
    .in_ready  (irdy5),
    .out_data  (odata5),
    .out_valid (ovalid5),
    .out_ready (oready5),
    .out_src   (osrc5)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (ovalid8 !== 1'b0 || odata8 !== 32'h0 || osrc8 !== 3'd0) begin
      errors++;
      $display("FAIL reset_init8 v=%b d=%h s=%0d want 0/0/0", ovalid8, odata8, osrc8);
    end
    checks++;
    if (ovalid5 !== 1'b0 || odata5 !== 16'h0 || osrc5 !== 3'd0) begin
      errors++;
      $display("FAIL reset_init5 v=%b d=%h s=%0d want 0/0/0", ovalid5, odata5, osrc5);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    mode8 = MODE_DIRECT;
    sel8 = 3'd3;
    valid8 = 8'hFF;
    data8[3*32 +: 32] = 32'h1111_2222;
    oready8 = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid8 !== 1'b1 || odata8 !== 32'h1111_2222) begin
      errors++;
      $display("FAIL reset_preload v=%b d=%h want 1/11112222", ovalid8, odata8);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (ovalid8 !== 1'b0 || odata8 !== 32'h0 || osrc8 !== 3'd0) begin
      errors++;
      $display("FAIL reset_async v=%b d=%h s=%0d want 0/0/0", ovalid8, odata8, osrc8);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    mode8 = MODE_RR;
    valid8 = 8'b0110_0000;
    data8[5*32 +: 32] = 32'h5555_AAAA;
    oready8 = 1'b1;
    #1;
    checks++;
    if (irdy8 !== 8'h20) begin
      errors++;
      $display("FAIL reset_first_rr_ready got=%h want=20", irdy8);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid8 !== 1'b1 || osrc8 !== 3'd5 || odata8 !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL reset_first_rr v=%b s=%0d d=%h want 1/5/5555aaaa", ovalid8, osrc8, odata8);
    end
  endtask

  task automatic test_direct();
    @(negedge Clk);
    for (int i = 0; i < 8; i++) data8[i*32 +: 32] = $urandom;
    data8[3*32 +: 32] = 32'hDEAD_BEEF;
    mode8 = MODE_DIRECT;
    sel8 = 3'd3;
    valid8 = 8'hFF;
    oready8 = 1'b1;
    #1;
    checks++;
    if (irdy8 !== 8'h08) begin
      errors++;
      $display("FAIL direct_ready got=%h want=08", irdy8);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid8 !== 1'b1 || odata8 !== 32'hDEAD_BEEF || osrc8 !== 3'd3) begin
      errors++;
      $display("FAIL direct_out v=%b d=%h s=%0d want 1/deadbeef/3", ovalid8, odata8, osrc8);
    end
  endtask

  task automatic test_round_robin();
    int exp_src[6] = '{0, 2, 5, 7, 0, 2};
    logic [31:0] want;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge Clk);
      for (int i = 0; i < 8; i++) data8[i*32 +: 32] = 32'hC0DE_0000 + 32'(c*256 + i);
      mode8 = MODE_RR;
      valid8 = 8'b1010_0101;
      oready8 = 1'b1;
      #1;
      checks++;
      if (irdy8 !== 8'(1 << exp_src[c])) begin
        errors++;
        $display("FAIL rr_ready[%0d] got=%h want=%h", c, irdy8, 8'(1 << exp_src[c]));
      end
      want = 32'hC0DE_0000 + 32'(c*256 + exp_src[c]);
      @(posedge Clk);
      #1;
      checks++;
      if (ovalid8 !== 1'b1 || osrc8 !== 3'(exp_src[c]) || odata8 !== want) begin
        errors++;
        $display("FAIL rr_seq[%0d] v=%b s=%0d d=%h want 1/%0d/%h", c, ovalid8, osrc8, odata8, exp_src[c], want);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge Clk);
    mode8 = MODE_DIRECT;
    sel8 = 3'd1;
    valid8 = 8'h02;
    data8[1*32 +: 32] = 32'hAAAA_0001;
    oready8 = 1'b1;
    @(negedge Clk);
    oready8 = 1'b0;
    sel8 = 3'd4;
    valid8 = 8'h10;
    data8[4*32 +: 32] = 32'hBBBB_0004;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      checks++;
      if (irdy8 !== 8'h00) begin
        errors++;
        $display("FAIL bp_ready[%0d] got=%h want=00", c, irdy8);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (ovalid8 !== 1'b1 || odata8 !== 32'hAAAA_0001 || osrc8 !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d] v=%b d=%h s=%0d want 1/aaaa0001/1", c, ovalid8, odata8, osrc8);
      end
    end
    @(negedge Clk);
    oready8 = 1'b1;
    #1;
    checks++;
    if (irdy8 !== 8'h10) begin
      errors++;
      $display("FAIL bp_release_ready got=%h want=10", irdy8);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid8 !== 1'b1 || odata8 !== 32'hBBBB_0004 || osrc8 !== 3'd4) begin
      errors++;
      $display("FAIL bp_release v=%b d=%h s=%0d want 1/bbbb0004/4", ovalid8, odata8, osrc8);
    end
  endtask

  task automatic test_random();
    logic        mv;
    logic [31:0] md;
    int          ms;
    int          mp;
    int          g;
    bit          any;
    bit          can;
    logic [7:0]  want_rdy;
    do_reset();
    mv = 1'b0;
    md = '0;
    ms = 0;
    mp = 7;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge Clk);
      for (int i = 0; i < 8; i++) data8[i*32 +: 32] = $urandom;
      mode8 = 1'($urandom_range(0, 1));
      sel8 = 3'($urandom_range(0, 7));
      valid8 = 8'($urandom) & 8'($urandom);
      oready8 = ($urandom_range(0, 3) != 0);
      g = 0;
      any = 0;
      if (mode8 == MODE_DIRECT) begin
        g = int'(sel8);
        any = valid8[g];
      end else begin
        for (int k = 1; k <= 8 && !any; k++) begin
          if (valid8[(mp + k) % 8]) begin
            g = (mp + k) % 8;
            any = 1;
          end
        end
      end
      can = !mv || oready8;
      want_rdy = (can && any) ? 8'(1 << g) : 8'h00;
      #1;
      checks++;
      if (irdy8 !== want_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d] got=%h want=%h", c, irdy8, want_rdy);
      end
      if (can && any) begin
        mv = 1'b1;
        md = data8[g*32 +: 32];
        ms = g;
        if (mode8 == MODE_RR) mp = g;
      end else if (oready8) begin
        mv = 1'b0;
      end
      @(posedge Clk);
      #1;
      checks++;
      if (ovalid8 !== mv || (mv && (odata8 !== md || osrc8 !== 3'(ms)))) begin
        errors++;
        $display("FAIL rand_out[%0d] v=%b d=%h s=%0d want %b/%h/%0d", c, ovalid8, odata8, osrc8, mv, md, ms);
      end
    end
  endtask

  task automatic test_n5_edges();
    do_reset();
    mode5 = MODE_DIRECT;
    sel5 = 3'd2;
    valid5 = 5'h1F;
    for (int i = 0; i < 5; i++) data5[i*16 +: 16] = 16'h5000 + 16'(i);
    data5[2*16 +: 16] = 16'h1234;
    oready5 = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid5 !== 1'b1 || odata5 !== 16'h1234 || osrc5 !== 3'd2) begin
      errors++;
      $display("FAIL n5_load v=%b d=%h s=%0d want 1/1234/2", ovalid5, odata5, osrc5);
    end
    @(negedge Clk);
    sel5 = 3'd6;
    #1;
    checks++;
    if (irdy5 !== 5'h00) begin
      errors++;
      $display("FAIL n5_sel6_ready got=%h want=00", irdy5);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid5 !== 1'b0) begin
      errors++;
      $display("FAIL n5_sel6_drain v=%b want 0", ovalid5);
    end
    @(negedge Clk);
    sel5 = 3'd3;
    data5[3*16 +: 16] = 16'hBEEF;
    @(negedge Clk);
    oready5 = 1'b0;
    mode5 = MODE_RR;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      checks++;
      if (irdy5 !== 5'h00) begin
        errors++;
        $display("FAIL n5_switch_ready[%0d] got=%h want=00", c, irdy5);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (ovalid5 !== 1'b1 || odata5 !== 16'hBEEF || osrc5 !== 3'd3) begin
        errors++;
        $display("FAIL n5_switch_hold[%0d] v=%b d=%h s=%0d want 1/beef/3", c, ovalid5, odata5, osrc5);
      end
    end
    @(negedge Clk);
    oready5 = 1'b1;
    #1;
    checks++;
    if (irdy5 !== 5'h01) begin
      errors++;
      $display("FAIL n5_rr_ready got=%h want=01", irdy5);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ovalid5 !== 1'b1 || osrc5 !== 3'd0 || odata5 !== 16'h5000) begin
      errors++;
      $display("FAIL n5_rr_first v=%b s=%0d d=%h want 1/0/5000", ovalid5, osrc5, odata5);
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    mode8 = MODE_DIRECT;
    sel8 = '0;
    data8 = '0;
    valid8 = '0;
    oready8 = 1'b0;
    mode5 = MODE_DIRECT;
    sel5 = '0;
    data5 = '0;
    valid5 = '0;
    oready5 = 1'b0;
    test_reset();
    test_direct();
    test_round_robin();
    test_backpressure();
    test_random();
    test_n5_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
